// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared state type and parameter bounds
// for the switch debounce stage.
package sw_debounce_pkg;

   typedef enum logic {
      STABLE   = 1'b0,
      COUNTING = 1'b1
   } state_t;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 50000;

   localparam int MIN_SYNC_STAGES     = 2;
   localparam int MAX_SYNC_STAGES     = 4;
   localparam int MIN_DEBOUNCE_CYCLES = 1;
   localparam int MAX_DEBOUNCE_CYCLES = (1 << 20) - 1;

endpackage

// File: rtl/sw_debounce_chan.sv
// sw_debounce_chan: one switch channel - synchroniser, stability
// FSM/counter, and (with SW_DEBOUNCE_EDGE_EN) registered edge pulses.
module sw_debounce_chan
   import sw_debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_in,
   output logic sw_out,
   output logic sw_rise,
   output logic sw_fall
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_q;
   state_t                 state, state_d;
   logic [CW-1:0]          cnt, cnt_d;
   logic                   out_q, out_d;

   assign sync_q = sync[SYNC_STAGES-1];
   assign sw_out = out_q;

   // Shift the asynchronous level through the synchroniser chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], sw_in};
   end

   // State, stability counter and accepted level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= STABLE;
         cnt   <= '0;
         out_q <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         out_q <= out_d;
      end
   end

   // Next state: the glitch check comes before the threshold
   // check so a bounce on the final count still cancels.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      out_d   = out_q;
      unique case (state)
         STABLE: begin
            cnt_d = '0;
            if (sync_q != out_q) begin
               state_d = COUNTING;
               cnt_d   = CNT_ONE;
            end
         end
         COUNTING: begin
            if (sync_q == out_q) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt == CNT_MAX) begin
               state_d = STABLE;
               cnt_d   = '0;
               out_d   = ~out_q;
            end else begin
               cnt_d = cnt + CNT_ONE;
            end
         end
      endcase
   end

`ifdef SW_DEBOUNCE_EDGE_EN
   // Pulses are registered on the same edge as the level change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_rise <= 1'b0;
         sw_fall <= 1'b0;
      end else begin
         sw_rise <= ~out_q & out_d;
         sw_fall <= out_q & ~out_d;
      end
   end
`else
   assign sw_rise = 1'b0;
   assign sw_fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: NUM_SW independent debounced switch channels.
// Optional edge pulses enabled by macro SW_DEBOUNCE_EDGE_EN.
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int NUM_SW          = 4,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic              GlobalClock,
   input  logic              Reset,
   input  logic [NUM_SW-1:0] SW_IN,
   output logic [NUM_SW-1:0] SW_OUT,
   output logic [NUM_SW-1:0] SW_RISE,
   output logic [NUM_SW-1:0] SW_FALL
);

   if (SYNC_STAGES < MIN_SYNC_STAGES ||
       SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
      $fatal(1, "sw_debounce: SYNC_STAGES out of range");
   end

   if (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES ||
       DEBOUNCE_CYCLES > MAX_DEBOUNCE_CYCLES) begin : g_bad_deb
      $fatal(1, "sw_debounce: DEBOUNCE_CYCLES out of range");
   end

   for (genvar i = 0; i < NUM_SW; i++) begin : g_chan
      sw_debounce_chan #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
         .clk    (GlobalClock),
         .rst    (Reset),
         .sw_in  (SW_IN[i]),
         .sw_out (SW_OUT[i]),
         .sw_rise(SW_RISE[i]),
         .sw_fall(SW_FALL[i])
      );
   end

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed and random stimulus for sw_debounce,
// checked against a consecutive-run reference model.
module tb_sw_debounce;

   localparam int N  = 4;
   localparam int SS = 2;
   localparam int DC = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] sw_in;
   logic [N-1:0] sw_out, sw_rise, sw_fall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sw_debounce #(
      .NUM_SW         (N),
      .SYNC_STAGES    (SS),
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .GlobalClock(clk),
      .Reset      (rst),
      .SW_IN      (sw_in),
      .SW_OUT     (sw_out),
      .SW_RISE    (sw_rise),
      .SW_FALL    (sw_fall)
   );

   // Reference: a level is accepted once the synchronised input
   // has disagreed with the output on DC+1 consecutive edges.
   logic [N-1:0] hist [SS];
   int           run  [N];
   logic [N-1:0] m_out, m_rise, m_fall;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < SS; k++) hist[k] = '0;
         for (int i = 0; i < N; i++) run[i] = 0;
         m_out  = '0;
         m_rise = '0;
         m_fall = '0;
      end else begin
         m_rise = '0;
         m_fall = '0;
         for (int i = 0; i < N; i++) begin
            if (hist[SS-1][i] != m_out[i]) begin
               run[i] = run[i] + 1;
               if (run[i] == DC + 1) begin
                  run[i]   = 0;
                  m_out[i] = ~m_out[i];
                  if (m_out[i]) m_rise[i] = 1'b1;
                  else          m_fall[i] = 1'b1;
               end
            end else begin
               run[i] = 0;
            end
         end
         for (int k = SS - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = sw_in;
      end
   end

   function automatic logic [N-1:0] exp_edge(logic [N-1:0] v);
`ifdef SW_DEBOUNCE_EDGE_EN
      return v;
`else
      return '0;
`endif
   endfunction

   task automatic chk(string tag, logic [N-1:0] obs,
                      logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   int rise_cnt1;

   task automatic tick(string tag);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_out"},  sw_out,  m_out);
      chk({tag, "_rise"}, sw_rise, exp_edge(m_rise));
      chk({tag, "_fall"}, sw_fall, exp_edge(m_fall));
      chk({tag, "_excl"}, sw_rise & sw_fall, '0);
      rise_cnt1 += int'(sw_rise[1]);
   endtask

   task automatic ticks(string tag, int n);
      for (int j = 0; j < n; j++) tick(tag);
   endtask

   initial begin
      rise_cnt1 = 0;
      // Reset with all switches held high.
      sw_in = 4'hF;
      rst   = 1'b1;
      #1;
      chk("rst_async_out", sw_out, 4'h0);
      for (int j = 0; j < 3; j++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_hold_out",  sw_out,  4'h0);
         chk("rst_hold_rise", sw_rise, 4'h0);
         chk("rst_hold_fall", sw_fall, 4'h0);
      end
      rst = 1'b0;
      ticks("t1", 6);
      chk("t1_pre", sw_out, 4'h0);
      tick("t1");
      chk("t1_edge7",  sw_out,  4'hF);
      chk("t1_rise7",  sw_rise, exp_edge(4'hF));
      tick("t1");
      chk("t1_rise8",  sw_rise, 4'h0);

      // Clean step on bit 0 from a cleared state.
      sw_in = 4'h0;
      rst   = 1'b1;
      ticks("t2r", 2);
      rst = 1'b0;
      ticks("t2s", 3);
      sw_in = 4'h1;
      ticks("t2", 6);
      chk("t2_pre", sw_out, 4'h0);
      tick("t2");
      chk("t2_edge7", sw_out,  4'h1);
      chk("t2_rise7", sw_rise, exp_edge(4'h1));
      ticks("t2", 3);
      chk("t2_hold", sw_out, 4'h1);

      // Bounce on bit 1: 1,0,1,1,0 then held high.
      rise_cnt1 = 0;
      for (int j = 0; j < 5; j++) begin
         automatic logic [4:0] pat = 5'b01101;
         sw_in[1] = pat[j];
         tick("t3b");
         chk("t3_bounce", sw_out & 4'h2, 4'h0);
      end
      sw_in[1] = 1'b1;
      ticks("t3", 6);
      chk("t3_pre", sw_out, 4'h1);
      tick("t3");
      chk("t3_edge7", sw_out, 4'h3);
      ticks("t3", 3);
      chk("t3_pulses", N'(rise_cnt1), N'(exp_edge(4'h1)));

      // Bit 2 high for exactly DC sampled cycles: no toggle.
      sw_in[2] = 1'b1;
      ticks("t4", DC);
      sw_in[2] = 1'b0;
      for (int j = 0; j < 12; j++) begin
         tick("t4");
         chk("t4_out",   sw_out & 4'h4, 4'h0);
         chk("t4_pulse", (sw_rise | sw_fall) & 4'h4, 4'h0);
      end

      // Reset in the middle of a count on bit 3.
      sw_in[3] = 1'b1;
      ticks("t5", 4);
      rst = 1'b1;
      #1;
      chk("t5_async", sw_out, 4'h0);
      ticks("t5r", 2);
      rst = 1'b0;
      ticks("t5", 6);
      chk("t5_pre", sw_out, 4'h0);
      tick("t5");
      chk("t5_edge7", sw_out,  4'hB);
      chk("t5_rise7", sw_rise, exp_edge(4'hB));
      tick("t5");

      // Random bouncing with occasional resets.
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 5) == 0) sw_in[i] = ~sw_in[i];
         rst = ($urandom_range(0, 199) == 0);
         tick("rnd");
      end
      rst = 1'b0;
      ticks("rnd_tail", 12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
